// File: rtl/cpu_pkg.sv
// Shared types, widths and instruction-field helpers for the cpu core.
// Optional feature macro: CPU_HALT_EN (opcode E becomes HALT and adds the HALTED state).
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int NREGS  = 16;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_ADDI = 4'h8,
        OP_NOP9 = 4'h9,
        OP_JMP  = 4'hA,
        OP_BNZ  = 4'hB,
        OP_LD   = 4'hC,
        OP_ST   = 4'hD,
        OP_HALT = 4'hE,
        OP_LI   = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
`ifdef CPU_HALT_EN
        ST_LOAD,
        ST_HALTED
`else
        ST_LOAD
`endif
    } state_t;

    function automatic opcode_t f_op(input logic [DATA_W-1:0] instr);
        return opcode_t'(instr[15:12]);
    endfunction

    function automatic logic [3:0] f_rd(input logic [DATA_W-1:0] instr);
        return instr[11:8];
    endfunction

    function automatic logic [3:0] f_ra(input logic [DATA_W-1:0] instr);
        return instr[7:4];
    endfunction

    function automatic logic [3:0] f_rb(input logic [DATA_W-1:0] instr);
        return instr[3:0];
    endfunction

    function automatic logic [7:0] f_imm8(input logic [DATA_W-1:0] instr);
        return instr[7:0];
    endfunction

endpackage

// File: rtl/cpu_if.sv
// Shared instruction/data memory port between the cpu (master) and the word memory (slave).
interface cpu_if
    import cpu_pkg::*;
();
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (input mem_rdata, output mem_we, mem_addr, mem_wdata);
    modport slave  (output mem_rdata, input mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/cpu_register_file.sv
// 16x16 register file: one synchronous write port, three combinational read ports.
module register_file
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [3:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [3:0]        i_raddr_a,
    input  logic [3:0]        i_raddr_b,
    input  logic [3:0]        i_raddr_d,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic [DATA_W-1:0] o_rdata_d
);
    logic [DATA_W-1:0] registers [0:NREGS-1];

    // NOTE: the array is reset as registers (not a RAM macro) because all registers must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) registers[i] <= '0;
        end else if (i_we) begin
            registers[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = registers[i_raddr_a];
    assign o_rdata_b = registers[i_raddr_b];
    assign o_rdata_d = registers[i_raddr_d];
endmodule

// File: rtl/cpu.sv
// Multi-cycle 16-bit RISC core: FETCH/EXEC/LOAD sequencer, inline ALU, single shared memory port.
// Define CPU_HALT_EN to decode opcode E as HALT; otherwise opcode E is a NOP.
module cpu
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    cpu_if.master bus
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [3:0]        r_ld_rd;

    logic [DATA_W-1:0] w_instr;
    opcode_t           w_op;
    logic [7:0]        w_imm8;
    logic [3:0]        w_imm4;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_rd_d;
    logic [DATA_W-1:0] w_alu;
    logic              w_alu_we;
    logic              w_jump;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_ea;
    logic              w_rf_we;
    logic [3:0]        w_rf_waddr;
    logic [DATA_W-1:0] w_rf_wdata;

    // During EXEC the registered memory output is the word fetched in FETCH.
    assign w_instr  = bus.mem_rdata;
    assign w_op     = f_op(w_instr);
    assign w_imm8   = f_imm8(w_instr);
    assign w_imm4   = f_rb(w_instr);
    assign w_target = {w_imm8[7:1], 1'b0};
    assign w_ea     = w_rd_a[ADDR_W-1:0] + {4'b0000, w_imm4};

    register_file register_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_rf_we),
        .i_waddr   (w_rf_waddr),
        .i_wdata   (w_rf_wdata),
        .i_raddr_a (f_ra(w_instr)),
        .i_raddr_b (f_rb(w_instr)),
        .i_raddr_d (f_rd(w_instr)),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b),
        .o_rdata_d (w_rd_d)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no decode path can infer a latch.
        w_alu    = '0;
        w_alu_we = 1'b0;
        w_jump   = 1'b0;
        case (w_op)
            OP_ADD:  begin w_alu = w_rd_a + w_rd_b;                       w_alu_we = 1'b1; end
            OP_SUB:  begin w_alu = w_rd_a - w_rd_b;                       w_alu_we = 1'b1; end
            OP_AND:  begin w_alu = w_rd_a & w_rd_b;                       w_alu_we = 1'b1; end
            OP_OR:   begin w_alu = w_rd_a | w_rd_b;                       w_alu_we = 1'b1; end
            OP_XOR:  begin w_alu = w_rd_a ^ w_rd_b;                       w_alu_we = 1'b1; end
            OP_SHL:  begin w_alu = w_rd_a << w_imm4;                      w_alu_we = 1'b1; end
            OP_SHR:  begin w_alu = w_rd_a >> w_imm4;                      w_alu_we = 1'b1; end
            OP_ADDI: begin w_alu = w_rd_d + {{8{w_imm8[7]}}, w_imm8};     w_alu_we = 1'b1; end
            OP_LI:   begin w_alu = {8'h00, w_imm8};                       w_alu_we = 1'b1; end
            OP_JMP:  w_jump = 1'b1;
            OP_BNZ:  w_jump = (w_rd_d != '0);
            default: ;
        endcase
    end

    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_waddr = f_rd(w_instr);
        w_rf_wdata = w_alu;
        if (r_state == ST_EXEC) begin
            w_rf_we = w_alu_we;
        end else if (r_state == ST_LOAD) begin
            w_rf_we    = 1'b1;
            w_rf_waddr = r_ld_rd;
            w_rf_wdata = bus.mem_rdata;
        end
    end

    // Memory port is decoded from state so reset drops mem_we immediately.
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = r_pc;
        bus.mem_wdata = '0;
        if (r_state == ST_EXEC && (w_op == OP_LD || w_op == OP_ST)) bus.mem_addr = w_ea;
        if (r_state == ST_EXEC && w_op == OP_ST) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = w_rd_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_ld_rd <= '0;
        end else begin
            case (r_state)
                ST_FETCH: r_state <= ST_EXEC;
                ST_EXEC: begin
                    r_pc    <= w_jump ? w_target : r_pc + 8'd2;
                    r_ld_rd <= f_rd(w_instr);
                    r_state <= (w_op == OP_LD) ? ST_LOAD : ST_FETCH;
`ifdef CPU_HALT_EN
                    if (w_op == OP_HALT) r_state <= ST_HALTED;
`endif
                end
                ST_LOAD: r_state <= ST_FETCH;
`ifdef CPU_HALT_EN
                ST_HALTED: r_state <= ST_HALTED;
`endif
                default: r_state <= ST_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Directed-program bench for cpu: a scoreboard checks every memory store, register/pc peeks check the rest.
module tb_cpu;
    logic clk;
    logic rst_n;
    logic load_req;

    cpu_if bus ();

    cpu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } store_t;

    store_t      exp_q[$];
    logic [15:0] mem [0:127];
    logic [15:0] img [0:127];
    int          n_checks;
    int          n_errors;
    int          we_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous word memory: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 128; i++) mem[i] <= img[i];
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:1]] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr[7:1]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with mem_we high must match the next expected store.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL store_unexpected: got addr=0x%0h data=0x%0h expected no store",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                store_t e;
                e = exp_q.pop_front();
                check("store_addr", {24'h0, bus.mem_addr}, {24'h0, e.addr});
                check("store_data", {16'h0, bus.mem_wdata}, {16'h0, e.data});
            end
        end
    end

    task automatic clear_img();
        for (int i = 0; i < 128; i++) img[i] = 16'h0000;
    endtask

    task automatic start_test();
        rst_n = 1'b0;
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        we_cnt   = 0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic end_test(input string name, input int exp_we);
        #1;
        check({name, "_we_cycles"}, we_cnt, exp_we);
        check({name, "_sb_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic logic [15:0] regs_or();
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) acc |= dut.register_file.registers[i];
        return acc;
    endfunction

    // Arithmetic program expectations: {register, value}.
    int          arith_reg [0:8];
    logic [15:0] arith_val [0:8];

    initial begin
        n_checks = 0;
        n_errors = 0;
        we_cnt   = 0;
        load_req = 1'b0;
        rst_n    = 1'b1;
        clear_img();
        #1;

        // Basic program: LI r1; LI r2; NOP; ST r1,[r2+2]
        img[0] = 16'hF10A; img[1] = 16'hF20A; img[2] = 16'h0000; img[3] = 16'hD122;
        start_test();
        check("rst_pc", dut.r_pc, 8'h00);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 8'h00);
        check("rst_mem_wdata", bus.mem_wdata, 16'h0000);
        check("rst_regs", regs_or(), 16'h0000);
        exp_q.push_back('{addr: 8'h0C, data: 16'h000A});
        release_rst();
        wait_cycles(2);
        check("basic_r1", dut.register_file.registers[1], 16'h000A);
        wait_cycles(2);
        check("basic_r2", dut.register_file.registers[2], 16'h000A);
        wait_cycles(3);
        check("basic_mem6_before", mem[6], 16'h0000);
        wait_cycles(1);
        check("basic_mem6_after", mem[6], 16'h000A);
        end_test("basic", 1);

        // Sign-extended ADDI: LI r3,FF; ADDI r3,1; LI r4,80; ADDI r4,80
        clear_img();
        img[0] = 16'hF3FF; img[1] = 16'h8301; img[2] = 16'hF480; img[3] = 16'h8480;
        start_test();
        release_rst();
        wait_cycles(8);
        check("addi_r3", dut.register_file.registers[3], 16'h0100);
        check("addi_r4", dut.register_file.registers[4], 16'h0000);
        end_test("addi", 0);

        // ALU ops, including same-register source and destination
        clear_img();
        img[0] = 16'hF10C; img[1] = 16'hF20A; img[2] = 16'h1512; img[3] = 16'h2621;
        img[4] = 16'h3712; img[5] = 16'h4812; img[6] = 16'h5912; img[7] = 16'h6A14;
        img[8] = 16'h7B64; img[9] = 16'h1111;
        arith_reg[0] = 5;  arith_val[0] = 16'h0016;
        arith_reg[1] = 6;  arith_val[1] = 16'hFFFE;
        arith_reg[2] = 7;  arith_val[2] = 16'h0008;
        arith_reg[3] = 8;  arith_val[3] = 16'h000E;
        arith_reg[4] = 9;  arith_val[4] = 16'h0006;
        arith_reg[5] = 10; arith_val[5] = 16'h00C0;
        arith_reg[6] = 11; arith_val[6] = 16'h0FFF;
        arith_reg[7] = 1;  arith_val[7] = 16'h0018;
        arith_reg[8] = 2;  arith_val[8] = 16'h000A;
        start_test();
        release_rst();
        wait_cycles(20);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("alu_r%0d", arith_reg[i]),
                  dut.register_file.registers[arith_reg[i]], arith_val[i]);
        end
        end_test("alu", 0);

        // Store then load: JMP 0x10; LI r1,5; ST r1,[r0+4]; LD r5,[r0+4]
        clear_img();
        img[0] = 16'hA010; img[8] = 16'hF105; img[9] = 16'hD104; img[10] = 16'hC504;
        start_test();
        exp_q.push_back('{addr: 8'h04, data: 16'h0005});
        release_rst();
        wait_cycles(8);
        check("ld_r5_pending", dut.register_file.registers[5], 16'h0000);
        check("ld_pc", dut.r_pc, 8'h16);
        wait_cycles(1);
        check("ld_r5", dut.register_file.registers[5], 16'h0005);
        check("ld_mem2", mem[2], 16'h0005);
        wait_cycles(3);
        end_test("ldst", 1);

        // Countdown loop: LI r6,3; ADDI r6,-1; BNZ r6,0x02; LI r7,0x55
        clear_img();
        img[0] = 16'hF603; img[1] = 16'h86FF; img[2] = 16'hB602; img[3] = 16'hF755;
        start_test();
        release_rst();
        wait_cycles(4);
        check("loop_r6_iter1", dut.register_file.registers[6], 16'h0002);
        wait_cycles(4);
        check("loop_r6_iter2", dut.register_file.registers[6], 16'h0001);
        wait_cycles(4);
        check("loop_r6_iter3", dut.register_file.registers[6], 16'h0000);
        wait_cycles(4);
        check("loop_r7", dut.register_file.registers[7], 16'h0055);
        check("loop_pc", dut.r_pc, 8'h08);
        end_test("loop", 0);

        // Odd jump target is forced even, then pc wraps 0xFE -> 0x00
        clear_img();
        img[0] = 16'hA0FF; img[127] = 16'hF155;
        start_test();
        release_rst();
        wait_cycles(2);
        check("wrap_jmp_pc", dut.r_pc, 8'hFE);
        wait_cycles(2);
        check("wrap_r1", dut.register_file.registers[1], 16'h0055);
        check("wrap_pc", dut.r_pc, 8'h00);
        end_test("wrap", 0);

        // Reset asserted during the EXEC of the store
        clear_img();
        img[0] = 16'hF10A; img[1] = 16'hF20A; img[2] = 16'h0000; img[3] = 16'hD122;
        start_test();
        release_rst();
        repeat (7) @(posedge clk);
        #1;
        check("abort_we_pre", bus.mem_we, 1'b1);
        check("abort_addr_pre", bus.mem_addr, 8'h0C);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_we", bus.mem_we, 1'b0);
        check("abort_pc", dut.r_pc, 8'h00);
        check("abort_regs", regs_or(), 16'h0000);
        wait_cycles(2);
        check("abort_mem6", mem[6], 16'h0000);
        end_test("abort", 0);

        // Opcode E at word 2: HALT when enabled, otherwise a NOP
        clear_img();
        img[0] = 16'hF10A; img[1] = 16'hF20A; img[2] = 16'hE000; img[3] = 16'hD122;
        start_test();
`ifdef CPU_HALT_EN
        release_rst();
        wait_cycles(6);
        check("halt_pc", dut.r_pc, 8'h06);
        wait_cycles(20);
        check("halt_pc_hold", dut.r_pc, 8'h06);
        check("halt_mem6", mem[6], 16'h0000);
        end_test("halt", 0);
`else
        exp_q.push_back('{addr: 8'h0C, data: 16'h000A});
        release_rst();
        wait_cycles(8);
        check("ope_nop_mem6", mem[6], 16'h000A);
        check("ope_nop_pc", dut.r_pc, 8'h08);
        end_test("ope_nop", 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end
endmodule
